// File: rtl/dist_avg_bcd.sv
// -----------------------------------------------------------------------------
// dist_avg_bcd
//
// Post-processing stage that sits between the echo-width distance counter and
// the four-digit seven-segment driver. Each accepted binary sample (cm) is
// pushed into a 2^AVG_LOG2-deep moving-average window. The average (or the raw
// sample while the window is still filling) is clamped to MAX_VAL. It is then
// converted to packed BCD by a sequential shift-add-3 (double-dabble) engine
// that takes one cycle per input bit.
//
// Ports:
//   sys_clk50m  in   50 MHz system clock
//   sys_rst     in   asynchronous, active-high reset
//   din         in   binary distance sample, IN_W bits
//   din_valid   in   one-cycle strobe qualifying din
//   bcd_out     out  packed BCD result (digit 3 in [15:12]), held between updates
//   bcd_valid   out  one-cycle pulse when bcd_out is updated
//   over_range  out  the average was clamped to MAX_VAL; updated with bcd_out
//   busy        out  a conversion is in progress
//   dropped     out  one-cycle pulse after a din_valid that arrived while busy
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module dist_avg_bcd #(
    parameter int IN_W     = 14,
    parameter int AVG_LOG2 = 2,
    parameter int MAX_VAL  = 9999
) (
    input  logic            sys_clk50m,
    input  logic            sys_rst,
    input  logic [IN_W-1:0] din,
    input  logic            din_valid,
    output logic [15:0]     bcd_out,
    output logic            bcd_valid,
    output logic            over_range,
    output logic            busy,
    output logic            dropped
);

    localparam int DEPTH  = 1 << AVG_LOG2;
    localparam int SUM_W  = IN_W + AVG_LOG2;
    localparam int CNT_W  = $clog2(IN_W + 1);
    localparam int FILL_W = AVG_LOG2 + 1;

    localparam logic [FILL_W-1:0] FULL      = FILL_W'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_SHFT = CNT_W'(IN_W - 1);
    localparam logic [IN_W-1:0]   MAX_V     = IN_W'(MAX_VAL);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SHIFT,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IN_W-1:0]       sample_q, sample_d;
    logic [IN_W-1:0]       win_q [DEPTH];
    logic [AVG_LOG2-1:0]   wrPtr_q, wrPtr_d;
    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [IN_W-1:0]       bin_q, bin_d;
    logic [15:0]           bcdAcc_q, bcdAcc_d;
    logic [CNT_W-1:0]      shiftCnt_q, shiftCnt_d;
    logic                  clamp_q, clamp_d;
    logic [15:0]           bcdOut_q, bcdOut_d;
    logic                  overRange_q, overRange_d;
    logic                  bcdValid_q, bcdValid_d;
    logic                  dropped_q, dropped_d;
    logic                  winWe;

    logic [IN_W-1:0]       oldest;
    logic [SUM_W-1:0]      sumNext;
    logic [FILL_W-1:0]     fillNext;
    logic [IN_W-1:0]       avgValue;
    logic [IN_W-1:0]       rawValue;
    logic [IN_W-1:0]       loadValue;
    logic                  loadClamp;
    logic [15:0]           bcdAdj;

    // Window arithmetic for the ACCUM cycle. The entry being overwritten is
    // zero until the window has wrapped once, because the buffer resets to
    // zero, so the running sum needs no special start-up handling.
    always_comb begin
        oldest   = win_q[wrPtr_q];
        sumNext  = sum_q - SUM_W'(oldest) + SUM_W'(sample_q);
        fillNext = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
        avgValue = sumNext[SUM_W-1:AVG_LOG2];
        rawValue = (fillNext < FULL) ? sample_q : avgValue;
        if (rawValue > MAX_V) begin
            loadValue = MAX_V;
            loadClamp = 1'b1;
        end else begin
            loadValue = rawValue;
            loadClamp = 1'b0;
        end
    end

    // Double-dabble correction: any BCD digit of 5 or more gets +3 so the
    // following left shift carries correctly into the next decimal digit.
    always_comb begin
        bcdAdj = bcdAcc_q;
        for (int n = 0; n < 4; n++) begin
            if (bcdAcc_q[4*n +: 4] >= 4'd5) begin
                bcdAdj[4*n +: 4] = bcdAcc_q[4*n +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath control. Pulse outputs default low so they can
    // only be high for the single cycle after the event that raised them.
    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        wrPtr_d     = wrPtr_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        bin_d       = bin_q;
        bcdAcc_d    = bcdAcc_q;
        shiftCnt_d  = shiftCnt_q;
        clamp_d     = clamp_q;
        bcdOut_d    = bcdOut_q;
        overRange_d = overRange_q;
        bcdValid_d  = 1'b0;
        dropped_d   = 1'b0;
        winWe       = 1'b0;

        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    sample_d = din;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                winWe      = 1'b1;
                sum_d      = sumNext;
                wrPtr_d    = wrPtr_q + 1'b1;
                fill_d     = fillNext;
                bin_d      = loadValue;
                clamp_d    = loadClamp;
                bcdAcc_d   = '0;
                shiftCnt_d = '0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                {bcdAcc_d, bin_d} = {bcdAdj, bin_q} << 1;
                shiftCnt_d        = shiftCnt_q + 1'b1;
                if (shiftCnt_q == LAST_SHFT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcdOut_d    = bcdAcc_q;
                overRange_d = clamp_q;
                bcdValid_d  = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A strobe while busy is discarded; nothing else reacts to it.
        if (state_q != IDLE && din_valid) begin
            dropped_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge sys_clk50m or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            sample_q    <= '0;
            wrPtr_q     <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            bin_q       <= '0;
            bcdAcc_q    <= '0;
            shiftCnt_q  <= '0;
            clamp_q     <= 1'b0;
            bcdOut_q    <= '0;
            overRange_q <= 1'b0;
            bcdValid_q  <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            wrPtr_q     <= wrPtr_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            bin_q       <= bin_d;
            bcdAcc_q    <= bcdAcc_d;
            shiftCnt_q  <= shiftCnt_d;
            clamp_q     <= clamp_d;
            bcdOut_q    <= bcdOut_d;
            overRange_q <= overRange_d;
            bcdValid_q  <= bcdValid_d;
            dropped_q   <= dropped_d;
        end
    end

    // Averaging window. Reset clears the history so the first sample after
    // a reset is passed straight through.
    always_ff @(posedge sys_clk50m or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
        end else if (winWe) begin
            win_q[wrPtr_q] <= sample_q;
        end
    end

    assign bcd_out    = bcdOut_q;
    assign bcd_valid  = bcdValid_q;
    assign over_range = overRange_q;
    assign busy       = (state_q != IDLE);
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_dist_avg_bcd.sv
`timescale 1ns/1ps
module tb_dist_avg_bcd;

    localparam int IN_W     = 14;
    localparam int AVG_LOG2 = 2;
    localparam int MAX_VAL  = 9999;
    localparam int WINDOW   = 1 << AVG_LOG2;
    localparam int LATENCY  = IN_W + 2;
    localparam int BOUND    = 60;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [IN_W-1:0] din = '0;
    logic            dinValid = 1'b0;
    logic [15:0]     bcdOut;
    logic            bcdValid;
    logic            overRange;
    logic            busy;
    logic            dropped;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state: the most recent accepted samples, oldest first.
    int hist[$];

    typedef struct {
        bit              newReset;
        logic [IN_W-1:0] din;
        logic [15:0]     expOut;
        logic            expOvr;
    } vec_t;

    vec_t vecs[15];

    dist_avg_bcd #(
        .IN_W(IN_W),
        .AVG_LOG2(AVG_LOG2),
        .MAX_VAL(MAX_VAL)
    ) dut (
        .sys_clk50m(clk),
        .sys_rst(rst),
        .din(din),
        .din_valid(dinValid),
        .bcd_out(bcdOut),
        .bcd_valid(bcdValid),
        .over_range(overRange),
        .busy(busy),
        .dropped(dropped)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    // Compare one observed value against the bench's own expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Moving average over the accepted samples; pass-through until the
    // window is full, then clamp to the display range.
    function automatic int modelStep(input int v, output bit ovr);
        int sum;
        int val;
        hist.push_back(v);
        if (hist.size() > WINDOW) void'(hist.pop_front());
        if (hist.size() < WINDOW) begin
            val = v;
        end else begin
            sum = 0;
            foreach (hist[i]) sum += hist[i];
            val = sum / WINDOW;
        end
        ovr = (val > MAX_VAL);
        if (ovr) val = MAX_VAL;
        return val;
    endfunction

    function automatic logic [15:0] toBcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Assert reset between clock edges and confirm it acts immediately.
    task automatic doReset();
        @(negedge clk);
        dinValid = 1'b0;
        #5 rst = 1'b1;
        #1;
        checkOutput("rst_bcd_out", 32'(bcdOut), 32'h0);
        checkOutput("rst_bcd_valid", 32'(bcdValid), 32'h0);
        checkOutput("rst_over_range", 32'(overRange), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_dropped", 32'(dropped), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
    endtask

    // Strobe one sample and wait (bounded) for its result.
    task automatic applyStimulus(input logic [IN_W-1:0] v, output logic [15:0] outVal,
                                 output logic ovrVal, output int lat, output int busyCnt,
                                 output logic pulseAfter, output bit timedOut);
        int  cyc;
        bit  found;
        cyc     = 0;
        found   = 1'b0;
        busyCnt = 0;
        @(negedge clk);
        din      = v;
        dinValid = 1'b1;
        while (!found && cyc < BOUND) begin
            @(negedge clk);
            dinValid = 1'b0;
            cyc++;
            if (bcdValid === 1'b1) found = 1'b1;
            else if (busy === 1'b1) busyCnt++;
        end
        lat      = cyc - 1;
        outVal   = bcdOut;
        ovrVal   = overRange;
        timedOut = !found;
        @(negedge clk);
        pulseAfter = bcdValid;
    endtask

    task automatic runVector(input string tag, input logic [IN_W-1:0] v,
                             input logic [15:0] expOut, input logic expOvr);
        logic [15:0] outVal;
        logic        ovrVal;
        logic        pulseAfter;
        int          lat;
        int          busyCnt;
        bit          timedOut;
        applyStimulus(v, outVal, ovrVal, lat, busyCnt, pulseAfter, timedOut);
        checkOutput({tag, "_timeout"}, 32'(timedOut), 32'h0);
        checkOutput({tag, "_bcd_out"}, 32'(outVal), 32'(expOut));
        checkOutput({tag, "_over_range"}, 32'(ovrVal), 32'(expOvr));
        checkOutput({tag, "_latency"}, 32'(lat), 32'(LATENCY));
        checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'(LATENCY));
        checkOutput({tag, "_valid_pulse"}, 32'(pulseAfter), 32'h0);
    endtask

    initial begin
        int  expVal;
        bit  expOvr;
        int  cyc;
        int  validCnt;
        bit  found;
        logic [IN_W-1:0] rv;

        // Fill, wrap, clamp and drain-to-zero vectors with hand-derived results.
        vecs[0]  = '{1'b1, 14'd1234,  16'h1234, 1'b0};
        vecs[1]  = '{1'b1, 14'd100,   16'h0100, 1'b0};
        vecs[2]  = '{1'b0, 14'd200,   16'h0200, 1'b0};
        vecs[3]  = '{1'b0, 14'd300,   16'h0300, 1'b0};
        vecs[4]  = '{1'b0, 14'd401,   16'h0250, 1'b0};
        vecs[5]  = '{1'b0, 14'd5,     16'h0226, 1'b0};
        vecs[6]  = '{1'b1, 14'd12000, 16'h9999, 1'b1};
        vecs[7]  = '{1'b0, 14'd16000, 16'h9999, 1'b1};
        vecs[8]  = '{1'b0, 14'd16000, 16'h9999, 1'b1};
        vecs[9]  = '{1'b0, 14'd16000, 16'h9999, 1'b1};
        vecs[10] = '{1'b0, 14'd16000, 16'h9999, 1'b1};
        vecs[11] = '{1'b0, 14'd0,     16'h9999, 1'b1};
        vecs[12] = '{1'b0, 14'd0,     16'h8000, 1'b0};
        vecs[13] = '{1'b0, 14'd0,     16'h4000, 1'b0};
        vecs[14] = '{1'b0, 14'd0,     16'h0000, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        doReset();

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].newReset) doReset();
            expVal = modelStep(int'(vecs[i].din), expOvr);
            runVector($sformatf("vec%0d", i), vecs[i].din, vecs[i].expOut, vecs[i].expOvr);
        end

        // Strobe while busy is dropped; a strobe in the bcd_valid cycle is taken.
        doReset();
        @(negedge clk);
        din      = 14'd50;
        dinValid = 1'b1;
        cyc      = 0;
        @(negedge clk);
        dinValid = 1'b0;
        cyc++;
        repeat (3) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        cyc++;
        din      = 14'd77;
        dinValid = 1'b1;
        @(negedge clk);
        cyc++;
        dinValid = 1'b0;
        checkOutput("drop_pulse", 32'(dropped), 32'h1);
        @(negedge clk);
        cyc++;
        checkOutput("drop_once", 32'(dropped), 32'h0);
        found    = 1'b0;
        validCnt = 0;
        while (!found && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            if (bcdValid === 1'b1) found = 1'b1;
        end
        checkOutput("drop_timeout", 32'(found), 32'h1);
        checkOutput("drop_latency", 32'(cyc - 1), 32'(LATENCY));
        checkOutput("drop_bcd_out", 32'(bcdOut), 32'h0050);
        expVal   = modelStep(50, expOvr);
        din      = 14'd60;
        dinValid = 1'b1;
        @(negedge clk);
        dinValid = 1'b0;
        checkOutput("b2b_valid_low", 32'(bcdValid), 32'h0);
        checkOutput("b2b_no_drop", 32'(dropped), 32'h0);
        checkOutput("b2b_busy", 32'(busy), 32'h1);
        expVal = modelStep(60, expOvr);
        cyc    = 0;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (bcdValid === 1'b1) validCnt++;
        end
        checkOutput("b2b_valid_count", 32'(validCnt), 32'h1);
        checkOutput("b2b_bcd_out", 32'(bcdOut), 32'(toBcd(expVal)));
        checkOutput("b2b_over_range", 32'(overRange), 32'(expOvr));

        // Reset during SHIFT aborts the conversion and clears the history.
        doReset();
        runVector("pre1", 14'd1000, 16'h1000, 1'b0);
        runVector("pre2", 14'd2000, 16'h2000, 1'b0);
        runVector("pre3", 14'd3000, 16'h3000, 1'b0);
        @(negedge clk);
        din      = 14'd4000;
        dinValid = 1'b1;
        @(negedge clk);
        dinValid = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("abort_busy_before", 32'(busy), 32'h1);
        #5 rst = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_bcd_out", 32'(bcdOut), 32'h0);
        checkOutput("abort_bcd_valid", 32'(bcdValid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        validCnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (bcdValid === 1'b1) validCnt++;
        end
        checkOutput("abort_no_valid", 32'(validCnt), 32'h0);
        checkOutput("abort_out_held", 32'(bcdOut), 32'h0);
        expVal = modelStep(42, expOvr);
        runVector("post_abort", 14'd42, 16'h0042, 1'b0);

        // Randomized samples against the reference model.
        doReset();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) doReset();
            if ($urandom_range(0, 3) == 0) rv = IN_W'($urandom_range(0, (1 << IN_W) - 1));
            else rv = IN_W'($urandom_range(0, MAX_VAL));
            expVal = modelStep(int'(rv), expOvr);
            runVector($sformatf("rand%0d", i), rv, toBcd(expVal), expOvr);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dist_avg_bcd.md
Name: dist_avg_bcd

Overview:
- Post-processing stage between the raw echo-width distance counter and the four-digit seven-segment display driver.
- Accepts binary distance samples (cm) with a valid strobe and applies a 4-tap moving average.
- Clamps the result to display range, then runs a sequential shift-add-3 (double-dabble) conversion.
- Presents a registered 16-bit packed-BCD word (digit 3 in [15:12] … digit 0 in [3:0]) for the display's four nibble inputs.

Parameters:
- IN_W, 14, width of binary distance input.
- AVG_LOG2, 2, log2 of averaging window depth (window = 4 samples).
- MAX_VAL, 9999, largest displayable value; larger averages clamp to this.

Ports:
- sys_clk50m  input  1  system clock, 50 MHz.
- sys_rst  input  1  asynchronous, active-high reset.
- din  input  IN_W  binary distance sample.
- din_valid  input  1  one-cycle strobe qualifying din.
- bcd_out  output  16  packed BCD result, registered, held between updates.
- bcd_valid  output  1  one-cycle pulse when bcd_out is updated.
- over_range  output  1  set with bcd_out when clamping occurred; held until next update.
- busy  output  1  high while a conversion is in progress.
- dropped  output  1  one-cycle pulse when din_valid arrives while busy.

Behaviour:
- Clock domain and reset: single clock domain sys_clk50m. sys_rst is asynchronous, active-high, and clears all state immediately.
- Reset values: bcd_out=16'h0000; bcd_valid=0; over_range=0; busy=0; dropped=0; window buffer all zero; running sum=0; fill count=0; FSM=IDLE.
- FSM states: IDLE, ACCUM, SHIFT, DONE. busy = (state != IDLE).
- IDLE:
  - din_valid=1 → capture din; go to ACCUM.
  - Otherwise stay.
- ACCUM (1 cycle):
  - Write sample into the circular buffer at the write pointer.
  - sum_next = sum − oldest + din, where oldest is the entry being overwritten (zero until the buffer has been filled once). Sum width is IN_W+AVG_LOG2; it cannot overflow.
  - Pointer wraps modulo 2^AVG_LOG2.
  - Fill count saturates at 2^AVG_LOG2.
  - Value selection: if fill count (including this sample) < 2^AVG_LOG2, value = din (pass-through). Otherwise value = sum_next >> AVG_LOG2 (truncating).
  - If value > MAX_VAL: value = MAX_VAL and the clamp flag is set.
  - Load value into the shift register; clear the BCD accumulator; go to SHIFT.
- SHIFT (exactly IN_W cycles), per cycle:
  - Any BCD nibble ≥ 5 gets +3.
  - Then shift {bcd, bin} left by 1.
  - After the IN_Wth shift, go to DONE.
- DONE (1 cycle):
  - On exit: bcd_out ← accumulator; over_range ← clamp flag; bcd_valid=1 for exactly the following cycle; go to IDLE.
- Latency: din_valid sampled at edge E0 → bcd_valid high in the cycle after edge E0+IN_W+2, i.e. 16 cycles for IN_W=14.
- Back-to-back: a new din_valid is accepted in the same cycle bcd_valid is high, because the FSM is already in IDLE.
- din_valid while busy: the sample is discarded, with no effect on buffer, sum or fill count. dropped pulses for one cycle, in the cycle after the strobe.
- bcd_valid and dropped are never high for more than one cycle per event.
- Reset mid-operation: conversion aborts; no bcd_valid; buffer history and fill count cleared, so the next sample is pass-through.
- Clamping guarantees every nibble of bcd_out is 0–9.

Test Plan:
1. Assert sys_rst asynchronously between clock edges → all outputs 0 immediately; bcd_out=16'h0000.
2. From reset, single din=1234 strobe → bcd_valid exactly 16 cycles later for one cycle; bcd_out=16'h1234; over_range=0; busy high 16 cycles.
3. Samples 100, 200, 300, 401 with gaps ≥16 cycles → bcd_out sequence 0100, 0200, 0300, 0250 (1001>>2=250); then fifth sample 5 → (200+300+401+5)>>2=226 → 16'h0226 (wrap replaces oldest).
4. Clamp:
   - From reset, din=12000 → 16'h9999, over_range=1.
   - Four samples of 16000 → 16'h9999, over_range=1.
   - Then samples 0,0,0,0 → final 16'h0000, over_range=0.
5. Strobe din=50, then din_valid=1 with din=77 at 5 cycles after → dropped pulses once; only one bcd_valid; bcd_out=16'h0050. Immediately strobing din=60 in the bcd_valid cycle is accepted, with no drop.
6. Reset asserted during SHIFT → no bcd_valid, bcd_out stays 16'h0000. Afterwards din=42 → 16'h0042 (pass-through, history cleared).
